board_ctrl: RTL and testbench

BOARD_CTRL -- requirements
Module: board_ctrl

---
 rtl/tictactoe_pkg.sv | 25 ++
 rtl/board_ctrl.sv | 127 ++++++++++++
 tb/tb_board_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/tictactoe_pkg.sv
// Shared types for the tic-tac-toe board controller: FSM state encoding,
// error codes and the board bit-index helper.
package tictactoe_pkg;

  // State values double as the external status code.
  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_CHECK = 2'd1,
    ST_WIN   = 2'd2,
    ST_DRAW  = 2'd3
  } state_e;

  localparam logic [1:0] ERR_NONE        = 2'd0;
  localparam logic [1:0] ERR_RANGE       = 2'd1;
  localparam logic [1:0] ERR_OCCUPIED    = 2'd2;
  localparam logic [1:0] ERR_NOT_PLAYING = 2'd3;

  localparam logic [3:0] MAX_MOVES = 4'd9;

  // P1 bit of cell (r,c); the P2 bit sits directly above it.
  function automatic logic [4:0] cell_idx(input logic [1:0] r, input logic [1:0] c);
    return {r, 3'b000} + {2'b00, c, 1'b0};
  endfunction

endpackage

// File: rtl/board_ctrl.sv
// Tic-tac-toe board controller: validates moves, maintains the board image
// and sequences PLAY/CHECK/WIN/DRAW using an external win detector.
//
// state | meaning
// PLAY  | waiting for a move from the player given by turn
// CHECK | one cycle: sample gameover for the board just written
// WIN   | game over, turn holds the winner
// DRAW  | game over, board full with no winner
module board_ctrl
  import tictactoe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        new_game,
  input  logic        move_valid,
  input  logic [1:0]  move_row,
  input  logic [1:0]  move_col,
  input  logic [9:0]  gameover,
  output logic [31:0] mem,
  output logic        move_ready,
  output logic        move_ack,
  output logic        move_err,
  output logic [1:0]  err_code,
  output logic        turn,
  output logic [3:0]  move_count,
  output logic [1:0]  status
);

  state_e      state_q;
  logic [31:0] mem_q;
  logic [31:0] mem_d;
  logic        turn_q;
  logic [3:0]  count_q;
  logic        ack_q;
  logic        err_q;
  logic [1:0]  err_code_q;

  logic [4:0]  idx;
  logic        in_range;
  logic        occupied;

  // Line bits are informational only; the controller decides on bits 9:8.
  logic        gameover_lines_unused;
  assign gameover_lines_unused = |gameover[7:0];

  always_comb begin
    idx      = cell_idx(move_row, move_col);
    in_range = (move_row != 2'd3) && (move_col != 2'd3);
    occupied = mem_q[{idx[4:1], 1'b0}] | mem_q[{idx[4:1], 1'b1}];
    mem_d    = mem_q;
    mem_d[{idx[4:1], turn_q}] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_PLAY;
      mem_q      <= '0;
      turn_q     <= 1'b0;
      count_q    <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      if (new_game) begin
        state_q    <= ST_PLAY;
        mem_q      <= '0;
        turn_q     <= 1'b0;
        count_q    <= '0;
        err_code_q <= ERR_NONE;
      end else begin
        case (state_q)
          ST_PLAY: begin
            if (move_valid) begin
              if (!in_range) begin
                err_q      <= 1'b1;
                err_code_q <= ERR_RANGE;
              end else if (occupied) begin
                err_q      <= 1'b1;
                err_code_q <= ERR_OCCUPIED;
              end else begin
                mem_q      <= mem_d;
                count_q    <= count_q + 4'd1;
                ack_q      <= 1'b1;
                err_code_q <= ERR_NONE;
                state_q    <= ST_CHECK;
              end
            end
          end
          ST_CHECK: begin
            if (move_valid) begin
              err_q      <= 1'b1;
              err_code_q <= ERR_NOT_PLAYING;
            end
            if (gameover[9]) begin
              state_q <= ST_WIN;
              turn_q  <= gameover[8];
            end else if (count_q == MAX_MOVES) begin
              state_q <= ST_DRAW;
            end else begin
              state_q <= ST_PLAY;
              turn_q  <= ~turn_q;
            end
          end
          ST_WIN, ST_DRAW: begin
            if (move_valid) begin
              err_q      <= 1'b1;
              err_code_q <= ERR_NOT_PLAYING;
            end
          end
          default: state_q <= ST_PLAY;
        endcase
      end
    end
  end

  assign mem        = mem_q;
  assign move_ready = (state_q == ST_PLAY);
  assign move_ack   = ack_q;
  assign move_err   = err_q;
  assign err_code   = err_code_q;
  assign turn       = turn_q;
  assign move_count = count_q;
  assign status     = state_q;

endmodule

// File: tb/tb_board_ctrl.sv
// Directed bench for board_ctrl; gameover comes from a behavioural win
// encoder driven by the DUT's board image.
module tb_board_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        new_game = 1'b0;
  logic        move_valid = 1'b0;
  logic [1:0]  move_row = 2'd0;
  logic [1:0]  move_col = 2'd0;
  logic [9:0]  gameover;
  logic [31:0] mem;
  logic        move_ready;
  logic        move_ack;
  logic        move_err;
  logic [1:0]  err_code;
  logic        turn;
  logic [3:0]  move_count;
  logic [1:0]  status;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // bit0..2 rows, bit3..5 columns, bit6 diagonal, bit7 anti-diagonal
  function automatic logic [9:0] win_enc(input logic [31:0] m);
    logic [7:0] l1, l2;
    l1 = '0;
    l2 = '0;
    for (int r = 0; r < 3; r++) begin
      l1[r] = m[8*r] & m[8*r+2] & m[8*r+4];
      l2[r] = m[8*r+1] & m[8*r+3] & m[8*r+5];
    end
    for (int c = 0; c < 3; c++) begin
      l1[3+c] = m[2*c] & m[8+2*c] & m[16+2*c];
      l2[3+c] = m[2*c+1] & m[9+2*c] & m[17+2*c];
    end
    l1[6] = m[0] & m[10] & m[20];
    l2[6] = m[1] & m[11] & m[21];
    l1[7] = m[4] & m[10] & m[16];
    l2[7] = m[5] & m[11] & m[17];
    return {|(l1 | l2), |l2, l1 | l2};
  endfunction

  assign gameover = win_enc(mem);

  board_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .new_game   (new_game),
    .move_valid (move_valid),
    .move_row   (move_row),
    .move_col   (move_col),
    .gameover   (gameover),
    .mem        (mem),
    .move_ready (move_ready),
    .move_ack   (move_ack),
    .move_err   (move_err),
    .err_code   (err_code),
    .turn       (turn),
    .move_count (move_count),
    .status     (status)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_move(input logic [1:0] r, input logic [1:0] c);
    move_valid = 1'b1;
    move_row   = r;
    move_col   = c;
    tick();
    move_valid = 1'b0;
  endtask

  task automatic play(input logic [1:0] r, input logic [1:0] c);
    step_move(r, c);
    tick();
  endtask

  task automatic start_game();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (mem !== 32'h0) begin failures++; $display("FAIL rst_mem got=%h exp=%h", mem, 32'h0); end
    checks++; if (status !== 2'd0) begin failures++; $display("FAIL rst_status got=%0d exp=0", status); end
    checks++; if (turn !== 1'b0) begin failures++; $display("FAIL rst_turn got=%b exp=0", turn); end
    checks++; if (move_count !== 4'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", move_count); end
    checks++; if ({move_ack, move_err, err_code} !== 4'b0) begin failures++; $display("FAIL rst_pulses got=%b exp=0000", {move_ack, move_err, err_code}); end
    rst = 1'b0;
    tick();
    checks++; if (move_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", move_ready); end
  endtask

  task automatic test_first_move();
    start_game();
    step_move(2'd0, 2'd0);
    checks++; if (mem !== 32'h1) begin failures++; $display("FAIL first_mem got=%h exp=%h", mem, 32'h1); end
    checks++; if (move_ack !== 1'b1) begin failures++; $display("FAIL first_ack got=%b exp=1", move_ack); end
    checks++; if (status !== 2'd1 || move_ready !== 1'b0) begin failures++; $display("FAIL first_check got=%0d/%b exp=1/0", status, move_ready); end
    checks++; if (move_count !== 4'd1 || turn !== 1'b0) begin failures++; $display("FAIL first_count got=%0d/%b exp=1/0", move_count, turn); end
    tick();
    checks++; if (move_ack !== 1'b0) begin failures++; $display("FAIL first_ack_end got=%b exp=0", move_ack); end
    checks++; if (turn !== 1'b1) begin failures++; $display("FAIL first_turn got=%b exp=1", turn); end
    checks++; if (status !== 2'd0 || move_ready !== 1'b1) begin failures++; $display("FAIL first_latency got=%0d/%b exp=0/1", status, move_ready); end
  endtask

  task automatic test_errors();
    step_move(2'd0, 2'd0);
    checks++; if (move_err !== 1'b1 || move_ack !== 1'b0) begin failures++; $display("FAIL occ_pulse got=%b%b exp=10", move_err, move_ack); end
    checks++; if (err_code !== 2'd2) begin failures++; $display("FAIL occ_code got=%0d exp=2", err_code); end
    checks++; if (mem !== 32'h1 || status !== 2'd0) begin failures++; $display("FAIL occ_state got=%h/%0d exp=1/0", mem, status); end
    tick();
    checks++; if (move_err !== 1'b0 || err_code !== 2'd2) begin failures++; $display("FAIL occ_hold got=%b/%0d exp=0/2", move_err, err_code); end
    step_move(2'd3, 2'd1);
    checks++; if (move_err !== 1'b1 || err_code !== 2'd1) begin failures++; $display("FAIL range_code got=%b/%0d exp=1/1", move_err, err_code); end
    checks++; if (mem !== 32'h1 || turn !== 1'b1 || move_count !== 4'd1) begin failures++; $display("FAIL range_state got=%h/%b/%0d exp=1/1/1", mem, turn, move_count); end
    step_move(2'd1, 2'd3);
    checks++; if (err_code !== 2'd1) begin failures++; $display("FAIL range_col got=%0d exp=1", err_code); end
    play(2'd1, 2'd1);
    checks++; if (err_code !== 2'd0 || mem !== 32'h801) begin failures++; $display("FAIL p2_move got=%0d/%h exp=0/801", err_code, mem); end
    checks++; if (turn !== 1'b0 || move_count !== 4'd2) begin failures++; $display("FAIL p2_turn got=%b/%0d exp=0/2", turn, move_count); end
  endtask

  task automatic test_win_p1();
    start_game();
    play(2'd0, 2'd0);
    play(2'd1, 2'd0);
    play(2'd0, 2'd1);
    play(2'd1, 2'd1);
    play(2'd0, 2'd2);
    checks++; if (mem !== 32'h00000A15) begin failures++; $display("FAIL win_mem got=%h exp=00000a15", mem); end
    checks++; if (gameover !== 10'b10_00000001) begin failures++; $display("FAIL win_gameover got=%b exp=1000000001", gameover); end
    checks++; if (status !== 2'd2 || turn !== 1'b0) begin failures++; $display("FAIL win_status got=%0d/%b exp=2/0", status, turn); end
    checks++; if (move_count !== 4'd5 || move_ready !== 1'b0) begin failures++; $display("FAIL win_count got=%0d/%b exp=5/0", move_count, move_ready); end
    step_move(2'd2, 2'd2);
    checks++; if (move_err !== 1'b1 || err_code !== 2'd3 || move_ack !== 1'b0) begin failures++; $display("FAIL win_late_move got=%b/%0d/%b exp=1/3/0", move_err, err_code, move_ack); end
    checks++; if (mem !== 32'h00000A15 || status !== 2'd2) begin failures++; $display("FAIL win_late_state got=%h/%0d exp=a15/2", mem, status); end
    new_game   = 1'b1;
    move_valid = 1'b1;
    move_row   = 2'd1;
    move_col   = 2'd1;
    tick();
    new_game   = 1'b0;
    move_valid = 1'b0;
    checks++; if (mem !== 32'h0 || status !== 2'd0) begin failures++; $display("FAIL ng_clear got=%h/%0d exp=0/0", mem, status); end
    checks++; if (move_ack !== 1'b0 || move_err !== 1'b0 || err_code !== 2'd0) begin failures++; $display("FAIL ng_drop got=%b%b/%0d exp=00/0", move_ack, move_err, err_code); end
    checks++; if (move_count !== 4'd0 || turn !== 1'b0) begin failures++; $display("FAIL ng_count got=%0d/%b exp=0/0", move_count, turn); end
  endtask

  task automatic test_win_p2();
    start_game();
    play(2'd0, 2'd0);
    play(2'd1, 2'd0);
    play(2'd0, 2'd1);
    play(2'd1, 2'd1);
    play(2'd2, 2'd2);
    play(2'd1, 2'd2);
    checks++; if (mem !== 32'h00102A05) begin failures++; $display("FAIL p2win_mem got=%h exp=00102a05", mem); end
    checks++; if (gameover !== 10'h302) begin failures++; $display("FAIL p2win_gameover got=%h exp=302", gameover); end
    checks++; if (status !== 2'd2 || turn !== 1'b1) begin failures++; $display("FAIL p2win_turn got=%0d/%b exp=2/1", status, turn); end
  endtask

  task automatic test_draw();
    start_game();
    play(2'd0, 2'd0);
    play(2'd0, 2'd1);
    play(2'd0, 2'd2);
    play(2'd1, 2'd1);
    play(2'd1, 2'd0);
    play(2'd1, 2'd2);
    play(2'd2, 2'd1);
    play(2'd2, 2'd0);
    play(2'd2, 2'd2);
    checks++; if (move_count !== 4'd9) begin failures++; $display("FAIL draw_count got=%0d exp=9", move_count); end
    checks++; if (gameover !== 10'd0) begin failures++; $display("FAIL draw_gameover got=%b exp=0", gameover); end
    checks++; if (status !== 2'd3 || turn !== 1'b0) begin failures++; $display("FAIL draw_status got=%0d/%b exp=3/0", status, turn); end
    checks++; if (mem !== 32'h00162919) begin failures++; $display("FAIL draw_mem got=%h exp=00162919", mem); end
    step_move(2'd0, 2'd0);
    checks++; if (move_err !== 1'b1 || err_code !== 2'd3) begin failures++; $display("FAIL draw_late got=%b/%0d exp=1/3", move_err, err_code); end
  endtask

  task automatic test_back_to_back();
    start_game();
    step_move(2'd0, 2'd0);
    step_move(2'd1, 2'd1);
    checks++; if (move_err !== 1'b1 || err_code !== 2'd3 || move_ack !== 1'b0) begin failures++; $display("FAIL b2b_check_err got=%b/%0d/%b exp=1/3/0", move_err, err_code, move_ack); end
    checks++; if (mem !== 32'h1 || move_count !== 4'd1) begin failures++; $display("FAIL b2b_unchanged got=%h/%0d exp=1/1", mem, move_count); end
    checks++; if (move_ready !== 1'b1 || turn !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b/%b exp=1/1", move_ready, turn); end
    step_move(2'd1, 2'd1);
    checks++; if (move_ack !== 1'b1 || mem !== 32'h801 || err_code !== 2'd0) begin failures++; $display("FAIL b2b_second got=%b/%h/%0d exp=1/801/0", move_ack, mem, err_code); end
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    checks++; if (mem !== 32'h0 || status !== 2'd0 || turn !== 1'b0 || move_count !== 4'd0) begin failures++; $display("FAIL ng_in_check got=%h/%0d/%b/%0d exp=0/0/0/0", mem, status, turn, move_count); end
  endtask

  task automatic test_reset_mid_check();
    start_game();
    step_move(2'd2, 2'd2);
    checks++; if (status !== 2'd1 || move_ack !== 1'b1) begin failures++; $display("FAIL mid_pre got=%0d/%b exp=1/1", status, move_ack); end
    #2 rst = 1'b1;
    #1;
    checks++; if (move_ack !== 1'b0 || mem !== 32'h0) begin failures++; $display("FAIL mid_rst got=%b/%h exp=0/0", move_ack, mem); end
    checks++; if (status !== 2'd0 || move_count !== 4'd0 || turn !== 1'b0) begin failures++; $display("FAIL mid_state got=%0d/%0d/%b exp=0/0/0", status, move_count, turn); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (move_ready !== 1'b1 || move_ack !== 1'b0 || mem !== 32'h0) begin failures++; $display("FAIL mid_release got=%b/%b/%h exp=1/0/0", move_ready, move_ack, mem); end
  endtask

  initial begin
    test_reset();
    test_first_move();
    test_errors();
    test_win_p1();
    test_win_p2();
    test_draw();
    test_back_to_back();
    test_reset_mid_check();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
